lif_tick_scheduler: RTL and testbench
=====================================

Name: lif_tick_scheduler

Overview:
Time-multiplexes one leak/integrate/fire update datapath over NUM_NEURONS neurons, replacing one hard-wired LIF instance per neuron. Per-neuron membrane potential and refractory counters live in internal register arrays. On each tick the scheduler sweeps the neurons in index order.
- Neuron 0 is driven by the external current.
- Neuron k>0 is driven by weight[k] when neuron k-1 spiked on the previous tick, forming a feed-forward chain.
The block sits between the top-level pins and the spike/potential outputs.

Parameters:
NUM_NEURONS, 4, neurons in chain (2..16); IDX_W = clog2(NUM_NEURONS) derived localparam
WIDTH, 8, potential/current/weight width
THRESHOLD, 200, fire when post-integrate potential >= THRESHOLD
LEAK_SHIFT, 1, leak: v_leaked = v >> LEAK_SHIFT
REFRACTORY, 2, ticks a neuron is held at 0 after firing (0 = none)
WEIGHT_RST, 8'h80, reset value of every weight

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
ena  in  1  global enable; low freezes all state
tick_start  in  1  request one update sweep; sampled only in IDLE
ext_current  in  WIDTH  input current for neuron 0; latched when tick_start is accepted
cfg_we  in  1  weight write strobe
cfg_addr  in  IDX_W  weight index
cfg_wdata  in  WIDTH  weight value
busy  out  1  high whenever the FSM is not in IDLE
tick_done  out  1  one-cycle pulse at sweep completion
spikes  out  NUM_NEURONS  spike vector of the last completed tick
mon_sel  in  IDX_W  monitor select
mon_potential  out  WIDTH  combinational potential[mon_sel]; 0 if mon_sel >= NUM_NEURONS

Behaviour:
- Reset (rst_n=0 at a clk edge), including mid-sweep:
  - potentials, refractory counters, spikes, spikes_prev, latched current, index <= 0
  - weights <= WEIGHT_RST; FSM <= IDLE
  - busy = 0, tick_done = 0
- FSM states:
  - IDLE -> RUN: when ena && tick_start. Latch ext_current; snapshot spikes into spikes_prev; idx <= 0.
  - RUN: one neuron per cycle at index idx; idx++. After idx = NUM_NEURONS-1, go to DONE.
  - DONE: tick_done = 1 for one cycle; then IDLE.
- busy = (state != IDLE).
- Timing: tick_start accepted in cycle t. RUN occupies cycles t+1..t+N. DONE is cycle t+N+1. Back-to-back tick_start is accepted at t+N+2 at the earliest.
- Spike outputs:
  - each neuron's result accumulates in a next-spike vector during RUN
  - spikes <= next-spike vector on the edge entering DONE, so spikes updates coincident with tick_done
  - spikes is otherwise stable
- Neuron input: in0 = latched current; ink = spikes_prev[k-1] ? weight[k] : 0. weight[0] is stored but unused.
- Per-neuron update, one cycle:
  - if refr > 0: refr--, v <= 0, no spike
  - else: sum = (v >> LEAK_SHIFT) + in, computed at WIDTH+1 bits, saturated to 2^WIDTH-1
  - if sum >= THRESHOLD: spike = 1, v <= 0, refr <= REFRACTORY
  - else: v <= sum, spike = 0
- ena = 0: FSM, index, arrays and outputs hold. tick_start ignored. A pulse already in DONE is extended until ena returns.
- tick_start while busy: ignored; no queuing.
- cfg_we:
  - IDLE: writes weight[cfg_addr] at the edge
  - busy: ignored
  - cfg_addr >= NUM_NEURONS: ignored
  - a write in the same cycle tick_start is accepted takes effect for that tick

Decomposition:
- Package lif_pkg:
  - FSM state enum (IDLE, RUN, DONE)
  - default constants LIF_THRESHOLD, LIF_LEAK_SHIFT, LIF_REFRACTORY, LIF_WEIGHT_RST
  - saturating-add function
- Sub-module lif_update_core: purely combinational. Inputs (v, refr, in); outputs (v_next, refr_next, spike).
- Scheduler owns the FSM, the arrays, the config port and the monitor mux.

Test Plan:
- Reset mid-RUN (defaults, N=4) -> next cycle busy=0, spikes=0000, mon_potential=0 for all sel; every weight reads back effect 0x80.
- ext_current=120, repeated ticks -> neuron0 potential 120, 180, then spikes=0001 on tick3. Ticks 4 and 5: potential 0, bit0 = 0. Tick6: potential 120.
- All weights=200, ext_current=255 -> per-tick spikes 0001, 0010, 0100, 1001. Each tick_done arrives exactly 5 cycles after its tick_start.
- Instance THRESHOLD=255, ext_current=200 -> tick1 v=200, no spike; tick2 sum 300 saturates to 255 -> spike, v=0.
- tick_start held high continuously, plus cfg_we during RUN -> one sweep per N+2 cycles, busy pattern 1111 1 then 0. Weight unchanged after the busy write; the same write in IDLE applies.
- ena dropped for 3 cycles mid-RUN -> idx, potentials and busy frozen. tick_done is delayed by exactly 3 cycles; results are identical to the uninterrupted run.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared types, default constants and arithmetic helpers for the LIF tick scheduler.
package lif_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } lif_state_t;

  localparam int         LIF_THRESHOLD  = 200;
  localparam int         LIF_LEAK_SHIFT = 1;
  localparam int         LIF_REFRACTORY = 2;
  localparam logic [7:0] LIF_WEIGHT_RST = 8'h80;

  // Adds two unsigned values and clamps the result to 2^width - 1 (width < 32).
  function automatic logic [31:0] lif_sat_add(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input int unsigned width);
    logic [32:0] sum;
    logic [32:0] max;
    sum = {1'b0, a} + {1'b0, b};
    max = (33'd1 << width) - 33'd1;
    return (sum > max) ? max[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/lif_update_core.sv
// Combinational leak/integrate/fire step for a single neuron.
module lif_update_core
  import lif_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int THRESHOLD  = LIF_THRESHOLD,
  parameter int LEAK_SHIFT = LIF_LEAK_SHIFT,
  parameter int REFRACTORY = LIF_REFRACTORY,
  parameter int REFR_W     = 2
) (
  input  logic [WIDTH-1:0]  v,
  input  logic [REFR_W-1:0] refr,
  input  logic [WIDTH-1:0]  cur_in,
  output logic [WIDTH-1:0]  v_next,
  output logic [REFR_W-1:0] refr_next,
  output logic              spike
);

  logic [WIDTH-1:0] leaked;
  logic [31:0]      sum;

  assign leaked = v >> LEAK_SHIFT;
  assign sum    = lif_sat_add(32'(leaked), 32'(cur_in), WIDTH);

  always_comb begin
    v_next    = '0;
    refr_next = refr;
    spike     = 1'b0;
    if (refr != '0) begin
      refr_next = refr - 1'b1;
    end else if (sum >= 32'(THRESHOLD)) begin
      spike     = 1'b1;
      refr_next = REFR_W'(REFRACTORY);
    end else begin
      v_next = sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/lif_tick_scheduler.sv
// Sweeps one shared LIF update core over a feed-forward chain of neurons, one neuron per cycle.
module lif_tick_scheduler
  import lif_pkg::*;
#(
  parameter int               NUM_NEURONS = 4,
  parameter int               WIDTH       = 8,
  parameter int               THRESHOLD   = LIF_THRESHOLD,
  parameter int               LEAK_SHIFT  = LIF_LEAK_SHIFT,
  parameter int               REFRACTORY  = LIF_REFRACTORY,
  parameter logic [WIDTH-1:0] WEIGHT_RST  = LIF_WEIGHT_RST,
  localparam int              IDX_W       = $clog2(NUM_NEURONS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   tick_start,
  input  logic [WIDTH-1:0]       ext_current,
  input  logic                   cfg_we,
  input  logic [IDX_W-1:0]       cfg_addr,
  input  logic [WIDTH-1:0]       cfg_wdata,
  output logic                   busy,
  output logic                   tick_done,
  output logic [NUM_NEURONS-1:0] spikes,
  input  logic [IDX_W-1:0]       mon_sel,
  output logic [WIDTH-1:0]       mon_potential
);

  localparam int REFR_W = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;

  lif_state_t state, state_next;

  logic [WIDTH-1:0]       v_reg      [NUM_NEURONS];
  logic [REFR_W-1:0]      refr_reg   [NUM_NEURONS];
  logic [WIDTH-1:0]       weight_reg [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] spikes_reg, spikes_prev, next_spikes;
  logic [WIDTH-1:0]       cur_reg;
  logic [IDX_W-1:0]       idx;

  logic [WIDTH-1:0]  core_in, core_v_next;
  logic [REFR_W-1:0] core_refr_next;
  logic              core_spike;
  logic              last_idx;

  assign last_idx = (idx == IDX_W'(NUM_NEURONS - 1));

  // Neuron 0 sees the latched current; the rest see their weight only if the predecessor fired.
  assign core_in = (idx == '0) ? cur_reg
                 : (spikes_prev[idx - 1'b1] ? weight_reg[idx] : '0);

  lif_update_core #(
    .WIDTH     (WIDTH),
    .THRESHOLD (THRESHOLD),
    .LEAK_SHIFT(LEAK_SHIFT),
    .REFRACTORY(REFRACTORY),
    .REFR_W    (REFR_W)
  ) u_core (
    .v        (v_reg[idx]),
    .refr     (refr_reg[idx]),
    .cur_in   (core_in),
    .v_next   (core_v_next),
    .refr_next(core_refr_next),
    .spike    (core_spike)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (ena) begin
      case (state)
        ST_IDLE: if (tick_start) state_next = ST_RUN;
        ST_RUN:  if (last_idx)   state_next = ST_DONE;
        ST_DONE: state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        v_reg[i]      <= '0;
        refr_reg[i]   <= '0;
        weight_reg[i] <= WEIGHT_RST;
      end
      spikes_reg  <= '0;
      spikes_prev <= '0;
      next_spikes <= '0;
      cur_reg     <= '0;
      idx         <= '0;
    end else if (ena) begin
      case (state)
        ST_IDLE: begin
          if (cfg_we && (32'(cfg_addr) < NUM_NEURONS))
            weight_reg[cfg_addr] <= cfg_wdata;
          if (tick_start) begin
            cur_reg     <= ext_current;
            spikes_prev <= spikes_reg;
            next_spikes <= '0;
            idx         <= '0;
          end
        end
        ST_RUN: begin
          v_reg[idx]       <= core_v_next;
          refr_reg[idx]    <= core_refr_next;
          next_spikes[idx] <= core_spike;
          // The last neuron's spike is merged directly so spikes changes together with tick_done.
          if (last_idx)
            spikes_reg <= next_spikes | (NUM_NEURONS'(core_spike) << idx);
          else
            idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy          = (state != ST_IDLE);
  assign tick_done     = (state == ST_DONE);
  assign spikes        = spikes_reg;
  assign mon_potential = (32'(mon_sel) < NUM_NEURONS) ? v_reg[mon_sel] : '0;

endmodule

// File: tb/tb_lif_tick_scheduler.sv
// Directed and randomized checks of the LIF tick scheduler against a per-tick behavioural model.
module tb_lif_tick_scheduler;

  localparam int N = 4;

  logic       clk, rst_n, ena, tick_start, tick_start2, cfg_we;
  logic [7:0] ext_current, ext2, cfg_wdata, mon_potential, mon_potential2;
  logic [1:0] cfg_addr, mon_sel;
  logic       busy, busy2, tick_done, tick_done2;
  logic [3:0] spikes, spikes2;

  int vectors = 0;
  int miscompares = 0;

  // Model state: potentials, refractory counts, weights and last spike vector.
  int         mv[N], mr[N], mw[N];
  logic [N-1:0] mspk;

  lif_tick_scheduler dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .tick_start(tick_start),
    .ext_current(ext_current), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .busy(busy), .tick_done(tick_done),
    .spikes(spikes), .mon_sel(mon_sel), .mon_potential(mon_potential)
  );

  lif_tick_scheduler #(.THRESHOLD(255)) dut2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .tick_start(tick_start2),
    .ext_current(ext2), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .busy(busy2), .tick_done(tick_done2),
    .spikes(spikes2), .mon_sel(mon_sel), .mon_potential(mon_potential2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mv[k] = 0; mr[k] = 0; mw[k] = 128;
    end
    mspk = '0;
  endtask

  task automatic model_tick(input int cur);
    logic [N-1:0] prev;
    int inp, s;
    prev = mspk;
    for (int k = 0; k < N; k++) begin
      if (k == 0) inp = cur;
      else        inp = prev[k-1] ? mw[k] : 0;
      if (mr[k] > 0) begin
        mr[k]--; mv[k] = 0; mspk[k] = 1'b0;
      end else begin
        s = mv[k] / 2 + inp;
        if (s > 255) s = 255;
        if (s >= 200) begin
          mspk[k] = 1'b1; mv[k] = 0; mr[k] = 2;
        end else begin
          mspk[k] = 1'b0; mv[k] = s;
        end
      end
    end
  endtask

  task automatic check_state(input string tag);
    for (int k = 0; k < N; k++) begin
      mon_sel = 2'(k);
      #1;
      check($sformatf("%s_v%0d", tag, k), mon_potential, mv[k]);
    end
    check({tag, "_spikes"}, spikes, mspk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic cfg_write(input int addr, input int data);
    cfg_we = 1'b1; cfg_addr = 2'(addr); cfg_wdata = 8'(data);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    mw[addr] = data;
  endtask

  task automatic do_tick(input int cur, input bit we, input int addr, input int data, input bit stall);
    int n;
    bit seen;
    ext_current = 8'(cur);
    tick_start  = 1'b1;
    if (we) begin
      cfg_we = 1'b1; cfg_addr = 2'(addr); cfg_wdata = 8'(data);
      mw[addr] = data;
    end
    model_tick(cur);
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); n++; #1;
      if (n == 1) begin tick_start = 1'b0; cfg_we = 1'b0; end
      if (stall && n >= 3 && n <= 5) check("stall_busy", busy, 1);
      if (stall && n == 2) ena = 1'b0;
      if (stall && n == 5) ena = 1'b1;
      if (tick_done) seen = 1'b1;
    end
    check("latency", n, stall ? 8 : 5);
    check("spikes_at_done", spikes, mspk);
    @(posedge clk); #1;
    check("idle_busy", busy, 0);
    check("done_cleared", tick_done, 0);
    check_state("tick");
    $display("tick cur=%0d we=%0d addr=%0d data=%0d stall=%0d spikes=%b lat=%0d",
             cur, we, addr, data, stall, spikes, n);
  endtask

  task automatic do_tick2(input int cur, input int exp_v, input int exp_s);
    int n;
    ext2 = 8'(cur); tick_start2 = 1'b1;
    n = 0;
    while (!tick_done2 && n < 40) begin
      @(posedge clk); n++; #1;
      if (n == 1) tick_start2 = 1'b0;
    end
    check("thr255_latency", n, 5);
    @(posedge clk); #1;
    mon_sel = 2'd0; #1;
    check("thr255_v0", mon_potential2, exp_v);
    check("thr255_s0", spikes2[0], exp_s);
    $display("tick2 cur=%0d v0=%0d spikes=%b", cur, mon_potential2, spikes2);
  endtask

  int tab_v0[6] = '{120, 180, 0, 0, 0, 120};
  int tab_s0[6] = '{0, 0, 1, 0, 0, 0};
  int tab_chain[4] = '{1, 2, 4, 9};

  initial begin
    rst_n = 1'b0; ena = 1'b1; tick_start = 1'b0; tick_start2 = 1'b0;
    ext_current = '0; ext2 = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; mon_sel = '0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;

    // Reset asserted while a sweep is in progress.
    ext_current = 8'd255; tick_start = 1'b1;
    @(posedge clk); #1; tick_start = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_busy", busy, 1);
    do_reset();
    check("reset_busy", busy, 0);
    check("reset_done", tick_done, 0);
    check_state("reset");
    $display("reset mid-run busy=%0d spikes=%b", busy, spikes);

    // Default weights: neuron 1 integrates 0x80 after neuron 0 fires.
    do_tick(255, 0, 0, 0, 0);
    do_tick(255, 0, 0, 0, 0);
    mon_sel = 2'd1; #1;
    check("weight_rst_v1", mon_potential, 128);

    // Constant current of 120 on neuron 0, including refractory ticks.
    do_reset();
    for (int t = 0; t < 6; t++) begin
      do_tick(120, 0, 0, 0, 0);
      mon_sel = 2'd0; #1;
      check($sformatf("tab_v0_t%0d", t + 1), mon_potential, tab_v0[t]);
      check($sformatf("tab_s0_t%0d", t + 1), spikes[0], tab_s0[t]);
    end

    // Spike propagation along the chain with all weights at 200.
    do_reset();
    for (int k = 0; k < N; k++) cfg_write(k, 200);
    for (int t = 0; t < 4; t++) begin
      do_tick(255, 0, 0, 0, 0);
      check($sformatf("chain_t%0d", t + 1), spikes, tab_chain[t]);
    end

    // Saturating sum against a full-scale threshold.
    do_reset();
    do_tick2(200, 200, 0);
    do_tick2(200, 0, 1);

    // tick_start held high, with a weight write attempted while busy.
    do_reset();
    ext_current = 8'd255; tick_start = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      if (i % 6 == 0) model_tick(255);
      check($sformatf("held_busy_%0d", i), busy, (i % 6 != 5) ? 1 : 0);
      if (i % 6 == 4) check($sformatf("held_spikes_%0d", i), spikes, mspk);
      if (i == 1) begin cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = 8'h11; end
      if (i == 2) cfg_we = 1'b0;
      if (i == 17) tick_start = 1'b0;
    end
    check_state("held");
    $display("held tick_start sweeps=3 spikes=%b", spikes);
    for (int t = 0; t < 3; t++) do_tick(255, 0, 0, 0, 0);
    do_tick(255, 1, 1, 8'h11, 0);
    for (int t = 0; t < 3; t++) do_tick(255, 0, 0, 0, 0);

    // ena dropped for three cycles mid-sweep.
    do_tick(255, 0, 0, 0, 1);
    do_tick(150, 0, 0, 0, 1);

    // Randomized ticks, weight writes and stalls.
    for (int t = 0; t < 20; t++) begin
      do_tick($urandom_range(0, 255), ($urandom_range(0, 3) == 0),
              $urandom_range(0, N - 1), $urandom_range(0, 255),
              ($urandom_range(0, 4) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
